// File: rtl/cd_seg7_pkg.sv
// rtl/cd_seg7_pkg.sv - shared glyph constants and scan state type for the 7-seg scan controller
//
// Purpose : single home for the hex glyph table and the scan FSM state encoding.
// Contents: SEG_0..SEG_F  7-bit glyphs {a,b,c,d,e,f,g}, bit6 = a, active-high
//           SEG_OFF       all segments dark
//           scan_state_e  ST_BLANK (anti-ghost gap) / ST_SHOW (digit driven)

package cd_seg7_pkg;

    localparam logic [6:0] SEG_0   = 7'b1111110;
    localparam logic [6:0] SEG_1   = 7'b0110000;
    localparam logic [6:0] SEG_2   = 7'b1101101;
    localparam logic [6:0] SEG_3   = 7'b1111001;
    localparam logic [6:0] SEG_4   = 7'b0110011;
    localparam logic [6:0] SEG_5   = 7'b1011011;
    localparam logic [6:0] SEG_6   = 7'b1011111;
    localparam logic [6:0] SEG_7   = 7'b1110000;
    localparam logic [6:0] SEG_8   = 7'b1111111;
    localparam logic [6:0] SEG_9   = 7'b1111011;
    localparam logic [6:0] SEG_A   = 7'b1110111;
    localparam logic [6:0] SEG_B   = 7'b0011111;
    localparam logic [6:0] SEG_C   = 7'b1001110;
    localparam logic [6:0] SEG_D   = 7'b0111101;
    localparam logic [6:0] SEG_E   = 7'b1001111;
    localparam logic [6:0] SEG_F   = 7'b1000111;
    localparam logic [6:0] SEG_OFF = 7'b0000000;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } scan_state_e;

endpackage

// File: rtl/cd_hex7seg_dec.sv
// rtl/cd_hex7seg_dec.sv - combinational 4-bit hex to 7-segment glyph decoder
//
// Purpose: one shared decoder; the scan controller feeds it the nibble of the
//          digit currently being scanned.
// Ports  : nib_i  [3:0]  hex value 0..F
//          seg_o  [6:0]  glyph {a,b,c,d,e,f,g}, bit6 = a, active-high

module cd_hex7seg_dec
    import cd_seg7_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_OFF;
        case (nib_i)
            4'h0: seg_o = SEG_0;
            4'h1: seg_o = SEG_1;
            4'h2: seg_o = SEG_2;
            4'h3: seg_o = SEG_3;
            4'h4: seg_o = SEG_4;
            4'h5: seg_o = SEG_5;
            4'h6: seg_o = SEG_6;
            4'h7: seg_o = SEG_7;
            4'h8: seg_o = SEG_8;
            4'h9: seg_o = SEG_9;
            4'hA: seg_o = SEG_A;
            4'hB: seg_o = SEG_B;
            4'hC: seg_o = SEG_C;
            4'hD: seg_o = SEG_D;
            4'hE: seg_o = SEG_E;
            4'hF: seg_o = SEG_F;
            default: seg_o = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/cd_seg7_scan_ctrl.sv
// rtl/cd_seg7_scan_ctrl.sv - time-multiplexed N-digit 7-segment scan controller
//
// Purpose: scans N_DIGITS digits one at a time through a single shared decoder.
//          Each digit slot is REFRESH_DIV cycles: BLANK_CYCLES with every anode
//          off (anti-ghosting), then the digit is driven. New values are staged
//          in a pending register and copied to the displayed (shadow) register
//          only at the frame boundary, so a frame never mixes old and new digits.
// Ports  : clk        system clock, rising edge
//          rst_n      asynchronous reset, active-low
//          load_i     1-cycle strobe capturing digits_i/dp_i
//          digits_i   nibble k = digit k (digit 0 least significant)
//          dp_i       decimal point per digit, 1 = lit
//          en_i       per-digit enable, live; 0 keeps the anode off
//          lzb_i      leading-zero blanking enable, live
//          an_o       anode select, one-hot, polarity per AN_ACTIVE_LOW
//          seg_o      segments {a..g}, bit6 = a, active-high
//          dp_o       decimal point, active-high
//          frame_o    pulse aligned with the last output cycle of digit N_DIGITS-1

module cd_seg7_scan_ctrl
    import cd_seg7_pkg::*;
#(
    parameter int N_DIGITS      = 4,
    parameter int REFRESH_DIV   = 100000,
    parameter int BLANK_CYCLES  = 16,
    parameter bit AN_ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load_i,
    input  logic [4*N_DIGITS-1:0]   digits_i,
    input  logic [N_DIGITS-1:0]     dp_i,
    input  logic [N_DIGITS-1:0]     en_i,
    input  logic                    lzb_i,
    output logic [N_DIGITS-1:0]     an_o,
    output logic [6:0]              seg_o,
    output logic                    dp_o,
    output logic                    frame_o
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    localparam logic [CNT_W-1:0]    CNT_LAST       = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0]    CNT_BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0]    IDX_LAST       = IDX_W'(N_DIGITS - 1);
    // Inactive anode level; XOR with a one-hot yields the active pattern
    // for either polarity.
    localparam logic [N_DIGITS-1:0] AN_OFF         = {N_DIGITS{AN_ACTIVE_LOW}};

    // ---------------------------------------------------------------
    // State
    // ---------------------------------------------------------------
    scan_state_e               st_q, st_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [IDX_W-1:0]          idx_q, idx_d;

    logic [4*N_DIGITS-1:0]     pend_q, pend_d;
    logic [N_DIGITS-1:0]       pend_dp_q, pend_dp_d;
    logic                      pend_v_q, pend_v_d;
    logic [4*N_DIGITS-1:0]     shd_q, shd_d;
    logic [N_DIGITS-1:0]       shd_dp_q, shd_dp_d;

    logic [N_DIGITS-1:0]       an_q, an_d;
    logic [6:0]                seg_q, seg_d;
    logic                      dp_q, dp_d;
    logic                      frame_q, frame_d;

    logic                      slot_end;
    logic                      frame_end;

    assign slot_end  = (cnt_q == CNT_LAST);
    assign frame_end = slot_end && (idx_q == IDX_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q      <= ST_BLANK;
            cnt_q     <= '0;
            idx_q     <= '0;
            pend_q    <= '0;
            pend_dp_q <= '0;
            pend_v_q  <= 1'b0;
            shd_q     <= '0;
            shd_dp_q  <= '0;
            an_q      <= AN_OFF;
            seg_q     <= SEG_OFF;
            dp_q      <= 1'b0;
            frame_q   <= 1'b0;
        end else begin
            st_q      <= st_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            pend_q    <= pend_d;
            pend_dp_q <= pend_dp_d;
            pend_v_q  <= pend_v_d;
            shd_q     <= shd_d;
            shd_dp_q  <= shd_dp_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
            frame_q   <= frame_d;
        end
    end

    // ---------------------------------------------------------------
    // Scan FSM: slot counter and digit index
    // ---------------------------------------------------------------
    always_comb begin
        st_d  = st_q;
        cnt_d = cnt_q + 1'b1;
        idx_d = idx_q;
        case (st_q)
            ST_BLANK: begin
                if (cnt_q == CNT_BLANK_LAST) begin
                    st_d = ST_SHOW;
                end
            end
            ST_SHOW: begin
                if (slot_end) begin
                    st_d  = ST_BLANK;
                    cnt_d = '0;
                    idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
                end
            end
        endcase
    end

    // ---------------------------------------------------------------
    // Pending / shadow registers
    // A load on the boundary cycle itself bypasses pending so it lands in
    // the very next frame instead of waiting a whole extra frame.
    // ---------------------------------------------------------------
    always_comb begin
        pend_d    = pend_q;
        pend_dp_d = pend_dp_q;
        pend_v_d  = pend_v_q;
        shd_d     = shd_q;
        shd_dp_d  = shd_dp_q;
        if (frame_end) begin
            if (load_i) begin
                shd_d    = digits_i;
                shd_dp_d = dp_i;
                pend_v_d = 1'b0;
            end else if (pend_v_q) begin
                shd_d    = pend_q;
                shd_dp_d = pend_dp_q;
                pend_v_d = 1'b0;
            end
        end else if (load_i) begin
            pend_d    = digits_i;
            pend_dp_d = dp_i;
            pend_v_d  = 1'b1;
        end
    end

    // ---------------------------------------------------------------
    // Leading-zero blanking: walk down from the top digit; a digit is
    // blanked while every nibble from it upward is zero. Digit 0 is never
    // considered, so a value of zero still shows a single '0'.
    // ---------------------------------------------------------------
    logic [N_DIGITS-1:0] blank_vec;
    logic                zero_run;

    always_comb begin
        blank_vec = '0;
        zero_run  = lzb_i;
        for (int k = N_DIGITS - 1; k >= 1; k--) begin
            zero_run     = zero_run && (shd_q[4*k +: 4] == 4'h0);
            blank_vec[k] = zero_run;
        end
    end

    // ---------------------------------------------------------------
    // Shared decoder and registered outputs
    // ---------------------------------------------------------------
    logic [3:0]          cur_nib;
    logic [6:0]          dec_seg;
    logic [N_DIGITS-1:0] onehot;
    logic                drive;

    assign cur_nib = shd_q[4*int'(idx_q) +: 4];
    assign onehot  = {{(N_DIGITS-1){1'b0}}, 1'b1} << idx_q;
    assign drive   = (st_q == ST_SHOW) && en_i[idx_q] && !blank_vec[idx_q];

    cd_hex7seg_dec u_dec (
        .nib_i (cur_nib),
        .seg_o (dec_seg)
    );

    always_comb begin
        an_d    = AN_OFF;
        seg_d   = SEG_OFF;
        dp_d    = 1'b0;
        frame_d = frame_end;
        if (drive) begin
            an_d  = AN_OFF ^ onehot;
            seg_d = dec_seg;
            dp_d  = shd_dp_q[idx_q];
        end
    end

    assign an_o    = an_q;
    assign seg_o   = seg_q;
    assign dp_o    = dp_q;
    assign frame_o = frame_q;

endmodule

// File: tb/tb_cd_seg7_scan_ctrl.sv
// tb/tb_cd_seg7_scan_ctrl.sv - self-checking bench for cd_seg7_scan_ctrl

module tb_cd_seg7_scan_ctrl;

    localparam int N  = 4;
    localparam int RD = 8;
    localparam int BC = 2;
    localparam int FR = N * RD;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_i = 1'b0;
    logic [15:0] digits_i = '0;
    logic [3:0]  dp_i = '0;
    logic [3:0]  en_i = 4'hF;
    logic        lzb_i = 1'b0;
    logic [3:0]  an_o;
    logic [6:0]  seg_o;
    logic        dp_o;
    logic        frame_o;

    int errors = 0;
    int checks = 0;
    int s = 0;

    logic [15:0] cur_val, latest_val;
    logic [3:0]  cur_dp, latest_dp;
    logic [6:0]  glyph [16];

    typedef struct {
        logic [15:0]     val;
        logic [3:0]      dp;
        logic [3:0]      en;
        logic            lzb;
        logic [3:0]      on;
        logic [3:0][6:0] seg;
        logic [3:0]      dpx;
    } vec_t;

    vec_t tbl [7];

    cd_seg7_scan_ctrl #(
        .N_DIGITS      (N),
        .REFRESH_DIV   (RD),
        .BLANK_CYCLES  (BC),
        .AN_ACTIVE_LOW (1'b1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (load_i),
        .digits_i (digits_i),
        .dp_i     (dp_i),
        .en_i     (en_i),
        .lzb_i    (lzb_i),
        .an_o     (an_o),
        .seg_o    (seg_o),
        .dp_o     (dp_o),
        .frame_o  (frame_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s s=%0d: got %h want %h", name, s, act, exp);
        end
    endtask

    // Expected {an, seg, dp, frame} for scan position st, from slot arithmetic.
    function automatic logic [12:0] expect_out(input int st, input logic [15:0] val,
                                               input logic [3:0] dpv, input logic [3:0] en,
                                               input logic lzb);
        int         cnt = st % RD;
        int         idx = (st / RD) % N;
        logic [3:0] nib = 4'(val >> (4 * idx));
        logic       blanked = lzb && (idx != 0) && ((val >> (4 * idx)) == 16'h0);
        logic       act = (cnt >= BC) && en[idx] && !blanked;
        logic [3:0] an = act ? ~(4'b0001 << idx) : 4'hF;
        logic [6:0] sg = act ? glyph[nib] : 7'h00;
        logic       d  = act ? dpv[idx] : 1'b0;
        logic       fr = ((st % FR) == FR - 1);
        return {an, sg, d, fr};
    endfunction

    // One scan cycle: drive inputs for position s, clock, compare against the model.
    task automatic step(input logic ld, input logic [15:0] dv, input logic [3:0] dpv);
        load_i = ld;
        if (ld) begin
            digits_i = dv;
            dp_i     = dpv;
        end
        if (s % FR == 0) begin
            cur_val = latest_val;
            cur_dp  = latest_dp;
        end
        @(posedge clk);
        @(negedge clk);
        check("scan", {19'h0, an_o, seg_o, dp_o, frame_o},
              {19'h0, expect_out(s, cur_val, cur_dp, en_i, lzb_i)});
        if (ld) begin
            latest_val = dv;
            latest_dp  = dpv;
        end
        s++;
        load_i = 1'b0;
    endtask

    int          st_i;
    int          idx_i;
    int          pulses;
    logic        ld;
    logic [15:0] dv;
    logic [3:0]  an_x;

    initial begin
        glyph = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                  7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
        cur_val = '0; latest_val = '0; cur_dp = '0; latest_dp = '0;

        //            val       dp       en     lzb   on       seg[3..0]                       dpx
        tbl[0] = '{16'h1234, 4'b0000, 4'hF, 1'b0, 4'b1111, {7'h30, 7'h6D, 7'h79, 7'h33}, 4'b0000};
        tbl[1] = '{16'h0070, 4'b0000, 4'hF, 1'b1, 4'b0011, {7'h00, 7'h00, 7'h70, 7'h7E}, 4'b0000};
        tbl[2] = '{16'h0000, 4'b0000, 4'hF, 1'b1, 4'b0001, {7'h00, 7'h00, 7'h00, 7'h7E}, 4'b0000};
        tbl[3] = '{16'hABCF, 4'b0101, 4'hF, 1'b0, 4'b1111, {7'h77, 7'h1F, 7'h4E, 7'h47}, 4'b0101};
        tbl[4] = '{16'h1234, 4'b0000, 4'hB, 1'b0, 4'b1011, {7'h30, 7'h00, 7'h79, 7'h33}, 4'b0000};
        tbl[5] = '{16'h0070, 4'b0000, 4'hF, 1'b0, 4'b1111, {7'h7E, 7'h7E, 7'h70, 7'h7E}, 4'b0000};
        tbl[6] = '{16'h0800, 4'b1111, 4'hF, 1'b1, 4'b0111, {7'h00, 7'h7F, 7'h7E, 7'h7E}, 4'b0111};

        repeat (3) @(negedge clk);
        check("reset_init", {19'h0, an_o, seg_o, dp_o, frame_o}, {19'h0, 4'hF, 7'h00, 1'b0, 1'b0});
        rst_n = 1'b1;
        repeat (40) step(1'b0, '0, '0);

        // Table vectors: load mid-frame, check the whole following frame.
        for (int r = 0; r < 7; r++) begin
            en_i  = tbl[r].en;
            lzb_i = tbl[r].lzb;
            step(1'b1, tbl[r].val, tbl[r].dp);
            while (s % FR != 0) step(1'b0, '0, '0);
            for (int c = 0; c < FR; c++) begin
                st_i  = s;
                idx_i = (st_i / RD) % N;
                step(1'b0, '0, '0);
                if (st_i % RD == 5) begin
                    an_x = tbl[r].on[idx_i] ? ~(4'b0001 << idx_i) : 4'hF;
                    check("table", {20'h0, an_o, seg_o, dp_o},
                          {20'h0, an_x, tbl[r].seg[idx_i], tbl[r].dpx[idx_i]});
                end
            end
        end

        // Tearing: two loads inside one frame, only the later one appears next frame.
        en_i = 4'hF; lzb_i = 1'b0;
        while (s % FR != 3) step(1'b0, '0, '0);
        step(1'b1, 16'h1234, 4'h0);
        while (s % FR != 12) step(1'b0, '0, '0);
        step(1'b1, 16'h5678, 4'h0);
        while (s % FR != 0) step(1'b0, '0, '0);
        repeat (5) step(1'b0, '0, '0);
        check("tear_next", {25'h0, seg_o}, {25'h0, 7'h7F});

        // Load on the boundary cycle is shown in the immediately following frame.
        while (s % FR != FR - 1) step(1'b0, '0, '0);
        step(1'b1, 16'h9876, 4'h0);
        repeat (5) step(1'b0, '0, '0);
        check("bound_load", {25'h0, seg_o}, {25'h0, 7'h5F});

        // Frame period with a disabled digit.
        en_i = 4'b1011;
        pulses = 0;
        for (int i = 0; i < 3 * FR; i++) begin
            step(1'b0, '0, '0);
            if (frame_o) pulses++;
        end
        check("frame_count", pulses, 3);

        // Randomized traffic against the model.
        for (int i = 0; i < 800; i++) begin
            if (i % 8 == 0) begin
                en_i  = 4'($urandom);
                lzb_i = 1'($urandom);
            end
            ld = ($urandom_range(0, 5) == 0);
            dv = 16'($urandom) >> (4 * $urandom_range(0, 4));
            step(ld, dv, 4'($urandom));
        end

        // Asynchronous reset while a digit is lit.
        en_i = 4'hF; lzb_i = 1'b0;
        while (s % RD != 5) step(1'b0, '0, '0);
        check("pre_reset_lit", {31'h0, (an_o != 4'hF)}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("reset_async", {19'h0, an_o, seg_o, dp_o, frame_o}, {19'h0, 4'hF, 7'h00, 1'b0, 1'b0});
        repeat (2) @(negedge clk);
        check("reset_hold", {19'h0, an_o, seg_o, dp_o, frame_o}, {19'h0, 4'hF, 7'h00, 1'b0, 1'b0});
        rst_n = 1'b1;
        s = 0;
        cur_val = '0; latest_val = '0; cur_dp = '0; latest_dp = '0;
        repeat (2 * FR) step(1'b0, '0, '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
